// File: rtl/axi_addr_gen.sv
// AXI32 burst address generator: splits a byte-count command into INCR bursts
// of up to 16 four-byte beats, presented one at a time on a valid/ready port.
module axi_addr_gen #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       bytes_total,
  input  logic [31:0]       stride_bytes,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [7:0]        req_len,
  output logic              req_last,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [29:0]       rem_q, rem_d;
  logic [4:0]        beats;

  // stride is reserved and the sub-word byte count is dropped by design
  logic unused_inputs;
  assign unused_inputs = ^{stride_bytes, bytes_total[1:0]};

  function automatic logic [4:0] burst_beats(input logic [29:0] rem);
    return (rem > 30'd16) ? 5'd16 : rem[4:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    req_last  = 1'b0;
    done      = 1'b0;
    beats     = burst_beats(rem_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = base_addr;
          rem_d   = bytes_total[31:2];
          state_d = (bytes_total[31:2] != 30'd0) ? REQ : DONE;
        end
      end
      REQ: begin
        req_valid = 1'b1;
        req_addr  = ptr_q;
        req_len   = {3'b000, beats} - 8'd1;
        req_last  = (rem_q <= 30'd16);
        if (req_ready) begin
          ptr_d = ptr_q + ADDR_W'({beats, 2'b00});
          rem_d = rem_q - 30'(beats);
          if (req_last) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (start) begin
      assert (base_addr[1:0] == 2'b00)
        else $error("axi_addr_gen: unaligned base_addr %h on start", base_addr);
    end
  end
`endif

endmodule

// File: tb/tb_axi_addr_gen.sv
// Scoreboard bench for axi_addr_gen: expected bursts are queued per command and
// checked by a negedge monitor at each handshake; tasks check timing and counts.
module tb_axi_addr_gen;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        last;
  } burst_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [31:0]       bytes_total = '0;
  logic [31:0]       stride_bytes = '0;
  logic              req_valid;
  logic              req_ready = 1'b0;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;
  logic              req_last;
  logic              done;

  int     vectors = 0;
  int     errs = 0;
  int     cyc = 0;
  int     st_cyc = 0;
  int     done_cnt = 0;
  int     done_cyc = -1;
  burst_t sb[$];
  int     hs_q[$];

  axi_addr_gen #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .bytes_total(bytes_total), .stride_bytes(stride_bytes),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_last(req_last), .done(done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: scoreboard pops on handshake, stall stability, idle zeros, done width
  initial begin
    logic   stall, pdone;
    burst_t held, exp;
    stall = 1'b0;
    pdone = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        stall = 1'b0;
        pdone = 1'b0;
      end else begin
        if (done) begin
          vectors++;
          if (pdone) begin
            errs++;
            $display("FAIL done_width: done high %0d cycles in a row, required 1", 2);
          end
          done_cnt++;
          done_cyc = cyc;
        end
        if (stall) begin
          vectors++;
          if (req_valid !== 1'b1 || req_addr !== held.addr || req_len !== held.len ||
              req_last !== held.last) begin
            errs++;
            $display("FAIL stall_stable: got v=%b %h/%0d/%b, required v=1 %h/%0d/%b",
                     req_valid, req_addr, req_len, req_last, held.addr, held.len, held.last);
          end
        end
        if (req_valid === 1'b1 && req_ready === 1'b1) begin
          vectors++;
          if (sb.size() == 0) begin
            errs++;
            $display("FAIL burst_unexpected: got %h/%0d/%b, required no burst",
                     req_addr, req_len, req_last);
          end else begin
            exp = sb.pop_front();
            if (req_addr !== exp.addr || req_len !== exp.len || req_last !== exp.last) begin
              errs++;
              $display("FAIL burst: got %h/%0d/%b, required %h/%0d/%b",
                       req_addr, req_len, req_last, exp.addr, exp.len, exp.last);
            end
          end
          hs_q.push_back(cyc);
        end else if (req_valid !== 1'b1) begin
          vectors++;
          if (req_valid !== 1'b0 || req_addr !== '0 || req_len !== 8'd0 || req_last !== 1'b0) begin
            errs++;
            $display("FAIL idle_zero: got v=%b %h/%0d/%b, required all 0",
                     req_valid, req_addr, req_len, req_last);
          end
        end
        stall = (req_valid === 1'b1) && (req_ready !== 1'b1);
        held  = '{addr: req_addr, len: req_len, last: req_last};
        pdone = (done === 1'b1);
      end
    end
  end

  task automatic start_cmd(input logic [31:0] base, input logic [31:0] bytes);
    @(posedge clk); #1;
    base_addr    = base;
    bytes_total  = bytes;
    stride_bytes = $urandom;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    base_addr    = $urandom & 32'hFFFF_FFFC;
    bytes_total  = $urandom;
    st_cyc       = cyc;
  endtask

  task automatic wait_done(input bit bp, input int d0);
    for (int i = 1; i < 200 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      req_ready = bp ? ((i % 4) < 2) : 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({req_valid, req_addr, req_len, req_last, done} !== '0) begin
      errs++;
      $display("FAIL reset_state: got v=%b a=%h l=%0d last=%b d=%b, required all 0",
               req_valid, req_addr, req_len, req_last, done);
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({req_valid, req_addr, req_len, req_last, done} !== '0) begin
      errs++;
      $display("FAIL reset_release: got v=%b a=%h l=%0d last=%b d=%b, required all 0",
               req_valid, req_addr, req_len, req_last, done);
    end
  endtask

  task automatic test_single(input logic [31:0] base);
    int d0;
    hs_q.delete();
    sb.push_back('{addr: base, len: 8'd15, last: 1'b1});
    req_ready = 1'b1;
    start_cmd(base, 32'd64);
    d0 = done_cnt;
    vectors++;
    if (req_valid !== 1'b1) begin
      errs++;
      $display("FAIL single_valid_latency: got req_valid=%b, required 1", req_valid);
    end
    wait_done(1'b0, d0);
    vectors++;
    if (done_cnt != d0 + 1 || sb.size() != 0 || hs_q.size() != 1) begin
      errs++;
      $display("FAIL single_complete: got done=%0d left=%0d hs=%0d, required 1 0 1",
               done_cnt - d0, sb.size(), hs_q.size());
    end else begin
      vectors++;
      if (done_cyc != hs_q[0] + 1) begin
        errs++;
        $display("FAIL single_done_timing: got cycle %0d, required %0d", done_cyc, hs_q[0] + 1);
      end
    end
  endtask

  task automatic test_multi();
    int d0;
    hs_q.delete();
    for (int i = 0; i < 4; i++)
      sb.push_back('{addr: 32'h2000 + 32'(i * 64), len: 8'd15, last: (i == 3)});
    req_ready = 1'b1;
    start_cmd(32'h2000, 32'd256);
    d0 = done_cnt;
    wait_done(1'b0, d0);
    vectors++;
    if (done_cnt != d0 + 1 || sb.size() != 0 || hs_q.size() != 4) begin
      errs++;
      $display("FAIL multi_complete: got done=%0d left=%0d hs=%0d, required 1 0 4",
               done_cnt - d0, sb.size(), hs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (hs_q[i] != st_cyc + i) begin
          errs++;
          $display("FAIL multi_b2b[%0d]: got cycle %0d, required %0d", i, hs_q[i], st_cyc + i);
        end
      end
      vectors++;
      if (done_cyc != st_cyc + 4) begin
        errs++;
        $display("FAIL multi_done_timing: got cycle %0d, required %0d", done_cyc, st_cyc + 4);
      end
    end
  endtask

  task automatic test_backpressure();
    int d0;
    int exp_off[4] = '{0, 1, 4, 5};
    hs_q.delete();
    for (int i = 0; i < 4; i++)
      sb.push_back('{addr: 32'h3000 + 32'(i * 64), len: 8'd15, last: (i == 3)});
    req_ready = 1'b1;
    start_cmd(32'h3000, 32'd256);
    d0 = done_cnt;
    wait_done(1'b1, d0);
    vectors++;
    if (done_cnt != d0 + 1 || sb.size() != 0 || hs_q.size() != 4) begin
      errs++;
      $display("FAIL bp_complete: got done=%0d left=%0d hs=%0d, required 1 0 4",
               done_cnt - d0, sb.size(), hs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (hs_q[i] != st_cyc + exp_off[i]) begin
          errs++;
          $display("FAIL bp_hs[%0d]: got cycle %0d, required %0d", i, hs_q[i], st_cyc + exp_off[i]);
        end
      end
    end
    req_ready = 1'b1;
  endtask

  task automatic test_zero(input logic [31:0] bytes);
    int d0;
    hs_q.delete();
    req_ready = 1'b1;
    start_cmd(32'h4000, bytes);
    d0 = done_cnt;
    vectors++;
    if (req_valid !== 1'b0 || done !== 1'b1) begin
      errs++;
      $display("FAIL zero_outputs(%0d B): got valid=%b done=%b, required 0 1", bytes, req_valid, done);
    end
    wait_done(1'b0, d0);
    vectors++;
    if (done_cnt != d0 + 1 || hs_q.size() != 0 || done_cyc != st_cyc) begin
      errs++;
      $display("FAIL zero_done(%0d B): got done=%0d hs=%0d cyc=%0d, required 1 0 %0d",
               bytes, done_cnt - d0, hs_q.size(), done_cyc, st_cyc);
    end
  endtask

  task automatic test_partial();
    int d0;
    hs_q.delete();
    sb.push_back('{addr: 32'h5000, len: 8'd15, last: 1'b0});
    sb.push_back('{addr: 32'h5040, len: 8'd1,  last: 1'b1});
    req_ready = 1'b1;
    start_cmd(32'h5000, 32'd72);
    d0 = done_cnt;
    wait_done(1'b0, d0);
    vectors++;
    if (done_cnt != d0 + 1 || sb.size() != 0 || hs_q.size() != 2) begin
      errs++;
      $display("FAIL partial_complete: got done=%0d left=%0d hs=%0d, required 1 0 2",
               done_cnt - d0, sb.size(), hs_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    hs_q.delete();
    sb.push_back('{addr: 32'h6000, len: 8'd15, last: 1'b0});
    req_ready = 1'b1;
    start_cmd(32'h6000, 32'd256);
    d0 = done_cnt;
    @(posedge clk); #1;
    rstn      = 1'b1;
    req_ready = 1'b0;
    @(posedge clk); #1;
    rstn      = 1'b0;
    vectors++;
    if ({req_valid, req_addr, req_len, req_last, done} !== '0) begin
      errs++;
      $display("FAIL mid_reset_outputs: got v=%b a=%h l=%0d last=%b d=%b, required all 0",
               req_valid, req_addr, req_len, req_last, done);
    end
    req_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (done_cnt != d0 || sb.size() != 0 || hs_q.size() != 1) begin
      errs++;
      $display("FAIL mid_reset_abort: got done=%0d left=%0d hs=%0d, required 0 0 1",
               done_cnt - d0, sb.size(), hs_q.size());
    end
    test_single(32'h1000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single(32'h1000);
    test_multi();
    test_backpressure();
    test_zero(32'd0);
    test_zero(32'd3);
    test_partial();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/axi_addr_gen.md
AXI_ADDR_GEN -- requirements
Module: axi_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, giving the address width.
REQ-002 SHALL fix the beat size at 4 B (AXI32) and the maximum burst at 16 beats; these are not parameters.
REQ-003 SHALL have port `clk`, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port `rstn`, input, 1 bit: reset, synchronous and active-high (asserted when 1).
REQ-005 SHALL have port `start`, input, 1 bit: a one-cycle command pulse.
REQ-006 SHALL have port `base_addr`, input, ADDR_W bits: first byte address; 4-byte aligned.
REQ-007 SHALL have port `bytes_total`, input, 32 bits: transfer size in bytes.
REQ-008 SHALL have port `stride_bytes`, input, 32 bits: reserved; ignored in V1.
REQ-009 SHALL have port `req_valid`, output, 1 bit: a burst request is presented.
REQ-010 SHALL have port `req_ready`, input, 1 bit: the consumer accepts the request.
REQ-011 SHALL have port `req_addr`, output, ADDR_W bits: burst start address.
REQ-012 SHALL have port `req_len`, output, 8 bits: AXI LEN, equal to beats-1.
REQ-013 SHALL have port `req_last`, output, 1 bit: this is the final burst of the command.
REQ-014 SHALL have port `done`, output, 1 bit: one-cycle command-complete pulse.

Function
REQ-015 SHALL implement the FSM states IDLE, REQ and DONE.
REQ-016 In IDLE with start=1, SHALL latch base_addr into an address pointer and bytes_total[31:2] into a 30-bit remaining-beat counter.
  - Next state is REQ if the counter is nonzero; otherwise DONE.
REQ-017 SHALL ignore bytes_total[1:0]; a partial trailing word is not transferred.
REQ-018 SHALL ignore start outside IDLE; there is no queueing.
REQ-019 In REQ, SHALL drive req_valid=1 with the following outputs:
  - req_addr = pointer
  - req_len = min(remaining,16)-1
  - req_last = (remaining <= 16)
REQ-020 SHALL hold req_valid, req_addr, req_len and req_last stable until the handshake req_valid&&req_ready on a rising edge.
REQ-021 On a handshake, SHALL add beats*4 to the pointer (modulo 2^ADDR_W) and subtract beats from the remaining count.
  - If req_last was 1, next state is DONE; otherwise stay in REQ.
REQ-022 SHALL allow back-to-back bursts when req_ready stays high: one burst per cycle, no idle cycle between bursts.
REQ-023 SHALL assert req_valid in the cycle after start is sampled.
REQ-024 In DONE, SHALL assert done=1 for exactly one cycle, then return to IDLE.
  - done therefore rises one cycle after the final handshake.
  - For a zero-beat command, done rises one cycle after start.
REQ-025 SHALL never assert req_valid for a zero-beat command (bytes_total < 4).
REQ-026 SHALL NOT split bursts at 4 KB boundaries in V1; the caller supplies a 64-byte-aligned base for AXI compliance.
REQ-027 SHALL include a simulation-only assertion that fires ($error) when start=1 and base_addr[1:0] != 0.
REQ-028 SHALL drive req_addr, req_len and req_last as 0 whenever req_valid=0.

Reset
REQ-029 When rstn=1 at a clock edge, SHALL go to IDLE and clear all of the following:
  - req_valid=0, req_addr=0, req_len=0, req_last=0, done=0
  - the pointer and the remaining counter
REQ-030 A reset mid-command SHALL abort the command with no done pulse; the next start after reset release is processed normally.

Verification
REQ-031 The bench SHALL cover a single burst: base 0x1000, 64 B, req_ready=1.
  - Required: 1 burst {0x1000, len 15, last 1}, then a done pulse.
REQ-032 The bench SHALL cover multiple bursts: base 0x2000, 256 B, req_ready=1.
  - Required: 4 bursts at 0x2000, 0x2040, 0x2080, 0x20C0, each len 15; last=1 only on 0x20C0.
  - The bursts arrive on consecutive cycles.
REQ-033 The bench SHALL cover backpressure: base 0x3000, 256 B, req_ready pattern 1,1,0,0 repeating.
  - Required: the same 4-burst sequence as REQ-032 (relative to 0x3000), with outputs stable while not ready.
REQ-034 The bench SHALL cover a zero-length command: base 0x4000, 0 B.
  - Required: req_valid never asserted; done pulses one cycle after start.
REQ-035 The bench SHALL cover a partial final burst: base 0x5000, 72 B.
  - Required: bursts {0x5000, len 15, last 0} then {0x5040, len 1, last 1}.
REQ-036 The bench SHALL cover reset mid-operation: rstn=1 after the first handshake of a 256 B command.
  - Required: all outputs 0, no done pulse; a following 64 B command then completes per REQ-031.
